countdown_timer: RTL
====================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter busWidth, default 4: width of count value D/Q.
REQ-002 SHALL have parameter prescaleWidth, default 4: width of prescale value P.
REQ-003 SHALL have port clock  input  1  reference clock; all state changes on posedge clock.
REQ-004 SHALL have port masterReset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port D  input  busWidth  start/reload count value.
REQ-006 SHALL have port P  input  prescaleWidth  clocks per decrement, minus one.
REQ-007 SHALL have port start  input  1  load D and P, then begin counting down.
REQ-008 SHALL have port stop  input  1  abort counting and hold Q.
REQ-009 SHALL have port autoReload  input  1  restart from D after each expiry.
REQ-010 SHALL have port Q  output  busWidth  current count value.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port terminalCount  output  1  single-cycle expiry pulse.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; terminalCount = (state==DONE); busy = (state!=IDLE).
REQ-014 SHALL, in IDLE with start=1 and stop=0: load Q<=D and prescale counter<=P; next state RUN if D!=0, DONE if D==0.
REQ-015 SHALL hold Q and the prescale counter in IDLE while start=0.
REQ-016 SHALL generate tick in RUN when prescale counter==0; otherwise decrement the prescale counter by 1.
REQ-017 SHALL, on tick, set Q<=Q-1 and reload prescale counter<=P; if Q==1, enter DONE.
REQ-018 SHALL keep Q==0 during DONE, for exactly one cycle.
REQ-019 SHALL, on leaving DONE with autoReload=1: Q<=D, prescale<=P, next state RUN (DONE again if D==0).
REQ-020 SHALL, on leaving DONE with autoReload=0: go to IDLE.
REQ-021 SHALL give an expiry period of D*(P+1)+1 cycles under autoReload for D!=0.
REQ-022 SHALL, in RUN or DONE with stop=1: go to IDLE with Q held, no tick and no reload; terminalCount already high in DONE still completes its cycle.
REQ-023 SHALL give stop precedence over start in the same cycle, in every state.
REQ-024 SHALL, in RUN with start=1 and stop=0: restart by loading Q<=D and prescale<=P, with no terminalCount.
REQ-025 SHALL sample D and P only at load/reload instants; changes mid-count have no effect.
REQ-026 SHALL never let Q underflow; Q wraps neither below 0 nor above 2**busWidth-1.

Reset
REQ-027 SHALL, when masterReset=1 at a clock edge: state<=IDLE, Q<=0, prescale counter<=0; busy=0 and terminalCount=0 from that edge on.
REQ-028 SHALL give masterReset precedence over start, stop and tick, including mid-RUN and in DONE.
REQ-029 SHALL make Q and terminalCount known (non-X) from the first reset edge onward.

Structure
REQ-030 SHALL place the IDLE/RUN/DONE state encoding constants in a shared include/package file used by the design and the bench.
REQ-031 SHALL implement the prescaler as sub-module prescale_tick (inputs: clock, masterReset, load, P, enable; output: tick).
REQ-032 SHALL contain all count logic in one synchronous always block with no latches.

Verification
REQ-033 SHALL verify: D=3, P=0, one start pulse -> Q=3,2,1,0 on successive cycles; terminalCount high one cycle with Q=0; busy=0 after.
REQ-034 SHALL verify: D=2, P=2, autoReload=1 -> terminalCount pulses every 7 cycles for at least 4 periods; Q sequence 2,2,2,1,1,1,0.
REQ-035 SHALL verify: D=0, start -> DONE next cycle; one terminalCount pulse; IDLE after; Q=0.
REQ-036 SHALL verify: D=9, P=0, stop when Q=5 -> Q holds 5, busy=0, no terminalCount; start+stop same cycle -> stays IDLE.
REQ-037 SHALL verify: masterReset during RUN at Q=7 -> next edge Q=0, busy=0, terminalCount=0; start in DONE-adjacent cycle -> no pulse.
REQ-038 SHALL verify: D=15, P=15, autoReload=0 -> terminalCount exactly 240 cycles after start edge, once only.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: controller state encoding.
package countdown_timer_pkg;

   // Controller states: waiting for start, counting down, one-cycle expiry.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : countdown_timer_pkg

// File: rtl/countdown_timer_prescale_tick.sv
// Prescaler for the countdown timer: emits one tick every P+1 enabled clocks.
// P is captured on load so later changes on the P input have no effect until
// the next load.
module prescale_tick #(
   parameter int prescaleWidth = 4
) (
   input  logic                     clock,
   input  logic                     masterReset,
   input  logic                     load,
   input  logic [prescaleWidth-1:0] P,
   input  logic                     enable,
   output logic                     tick
);

   localparam logic [prescaleWidth-1:0] PS_ONE = prescaleWidth'(1);

   logic [prescaleWidth-1:0] r_cnt;
   logic [prescaleWidth-1:0] r_p;

   assign tick = enable && (r_cnt == '0);

   // Load counter and period; count down while enabled, reloading after each tick.
   always_ff @(posedge clock) begin
      if (masterReset) begin
         r_cnt <= '0;
         r_p   <= '0;
      end else if (load) begin
         r_cnt <= P;
         r_p   <= P;
      end else if (enable) begin
         if (r_cnt == '0) begin
            r_cnt <= r_p;
         end else begin
            r_cnt <= r_cnt - PS_ONE;
         end
      end
   end

endmodule : prescale_tick

// File: rtl/countdown_timer.sv
// Countdown timer: loads D/P on start, decrements Q every P+1 clocks and
// pulses terminalCount for one cycle when Q reaches zero. Optional auto-reload.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int busWidth      = 4,
   parameter int prescaleWidth = 4
) (
   input  logic                     clock,
   input  logic                     masterReset,
   input  logic [busWidth-1:0]      D,
   input  logic [prescaleWidth-1:0] P,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     autoReload,
   output logic [busWidth-1:0]      Q,
   output logic                     busy,
   output logic                     terminalCount
);

   localparam logic [busWidth-1:0] Q_ONE = busWidth'(1);

   state_t              r_state;
   state_t              w_state_next;
   logic [busWidth-1:0] r_q;
   logic                w_load;
   logic                w_enable;
   logic                w_tick;

   // The prescaler only advances in RUN when neither stop nor a restart is
   // requested, so stop freezes it and a restart reloads it cleanly.
   assign w_enable = (r_state == ST_RUN) && !stop && !start;

   prescale_tick #(
      .prescaleWidth(prescaleWidth)
   ) u_prescale (
      .clock       (clock),
      .masterReset (masterReset),
      .load        (w_load),
      .P           (P),
      .enable      (w_enable),
      .tick        (w_tick)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (masterReset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and load decision; stop always outranks start.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !stop) begin
               w_load       = 1'b1;
               w_state_next = (D != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (stop) begin
               w_state_next = ST_IDLE;
            end else if (start) begin
               w_load       = 1'b1;
               w_state_next = (D != '0) ? ST_RUN : ST_DONE;
            end else if (w_tick && (r_q == Q_ONE)) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (stop) begin
               w_state_next = ST_IDLE;
            end else if (autoReload) begin
               w_load       = 1'b1;
               w_state_next = (D != '0) ? ST_RUN : ST_DONE;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Count register: load on start/reload, decrement on tick. RUN is only
   // ever entered with a non-zero count and left when it hits zero, so the
   // decrement can never wrap.
   always_ff @(posedge clock) begin
      if (masterReset) begin
         r_q <= '0;
      end else if (w_load) begin
         r_q <= D;
      end else if (w_tick) begin
         r_q <= r_q - Q_ONE;
      end
   end

   assign Q             = r_q;
   assign busy          = (r_state != ST_IDLE);
   assign terminalCount = (r_state == ST_DONE);

endmodule : countdown_timer
